// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU memory-bus responder.
//   state_t        responder FSM states
//   LED_ADDR_DEF   default LED register address
//   SW_ADDR_DEF    default switch port address
//   IO_W           width of the LED register and switch port
//   is_io()        region decode: 1 when the address hits the I/O window
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] LED_ADDR_DEF = 8'hFE;
  localparam logic [7:0] SW_ADDR_DEF  = 8'hFF;
  localparam int         IO_W         = 10;

  // Arguments are widened to 32 bits so the decode works for any ADDR_W.
  function automatic logic is_io(input logic [31:0] addr,
                                 input logic [31:0] led_addr,
                                 input logic [31:0] sw_addr);
    return (addr == led_addr) || (addr == sw_addr);
  endfunction

endpackage

// File: rtl/io_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
//   clk    in   1      sampling clock
//   reset  in   1      asynchronous active-low reset, clears both stages
//   i_d    in   WIDTH  asynchronous input
//   o_q    out  WIDTH  synchronized output (two clk cycles of latency)
module io_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mem_bus_responder.sv
// Responder end of the CPU memory interface. Accepts one read or write at a
// time, routes it to RAM or to the memory-mapped LED/switch registers, and
// acknowledges with a one-cycle mready.
//
// Optional feature macro: MEM_BUS_WRITE_PROTECT_EN
//   When defined, RAM writes at or below PROTECT_TOP are acknowledged but
//   suppressed, and merr is raised with mready. When undefined merr stays 0.
//
// Ports
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous active-low reset
//   mreq       in   1       request valid (sampled in IDLE only)
//   mwrite     in   1       1 = write, 0 = read
//   address    in   ADDR_W  request address
//   wdata      in   DATA_W  write data
//   rdata      out  DATA_W  read data, valid while mready=1, held otherwise
//   mready     out  1       one-cycle acknowledge
//   merr       out  1       one-cycle protection fault, coincident with mready
//   ram_addr   out  ADDR_W  RAM address (registered)
//   ram_we     out  1       RAM write enable, first WAIT cycle only
//   ram_wdata  out  DATA_W  RAM write data (registered)
//   ram_rdata  in   DATA_W  RAM read data, valid one cycle after ram_addr
//   sw_in      in   10      asynchronous switches
//   led_out    out  10      LED register
//
// FSM
//   state | meaning
//   IDLE  | waiting for mreq; accepts and latches the request
//   WAIT  | RAM access in progress, wait counter running down
//   RESP  | mready (and merr) high for this single cycle
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int               DATA_W      = 16,
  parameter int               ADDR_W      = 8,
  parameter int               WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR   = LED_ADDR_DEF,
  parameter logic [ADDR_W-1:0] SW_ADDR    = SW_ADDR_DEF,
  parameter logic [ADDR_W-1:0] PROTECT_TOP = 8'h3F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mreq,
  input  logic              mwrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mready,
  output logic              merr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [IO_W-1:0]   sw_in,
  output logic [IO_W-1:0]   led_out
);

  localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam int               PAD_W    = DATA_W - IO_W;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic              r_fault;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mready;
  logic              r_merr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [IO_W-1:0]   r_led;

  logic              w_accept;
  logic              w_is_io;
  logic              w_prot_hit;
  logic [IO_W-1:0]   w_sw_sync;

  io_sync #(
    .WIDTH(IO_W)
  ) u_sw_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (sw_in),
    .o_q  (w_sw_sync)
  );

  assign w_accept = (r_state == IDLE) && mreq;
  assign w_is_io  = is_io(32'(address), 32'(LED_ADDR), 32'(SW_ADDR));

`ifdef MEM_BUS_WRITE_PROTECT_EN
  assign w_prot_hit = mwrite && !w_is_io && (address <= PROTECT_TOP);
`else
  logic w_unused_prot;
  assign w_unused_prot = ^PROTECT_TOP;
  assign w_prot_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (mreq) begin
          w_next = w_is_io ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // I/O accesses complete at the accept edge so their result is visible in
  // the RESP cycle; RAM accesses finish at the edge ending the last WAIT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_fault     <= 1'b0;
      r_rdata     <= '0;
      r_mready    <= 1'b0;
      r_merr      <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_led       <= '0;
    end else begin
      r_ram_we <= 1'b0;
      r_mready <= 1'b0;
      r_merr   <= 1'b0;

      if (w_accept) begin
        r_write <= mwrite;
        r_fault <= w_prot_hit;
        r_cnt   <= CNT_LOAD;
        if (w_is_io) begin
          r_mready <= 1'b1;
          if (mwrite) begin
            if (address == LED_ADDR) begin
              r_led <= wdata[IO_W-1:0];
            end
          end else if (address == LED_ADDR) begin
            r_rdata <= {{PAD_W{1'b0}}, r_led};
          end else begin
            r_rdata <= {{PAD_W{1'b0}}, w_sw_sync};
          end
        end else begin
          r_ram_addr  <= address;
          r_ram_wdata <= wdata;
          r_ram_we    <= mwrite && !w_prot_hit;
        end
      end

      if (r_state == WAIT) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end else begin
          r_mready <= 1'b1;
          r_merr   <= r_fault;
          if (!r_write) begin
            r_rdata <= ram_rdata;
          end
        end
      end
    end
  end

  assign rdata     = r_rdata;
  assign mready    = r_mready;
  assign merr      = r_merr;
  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_ram_wdata;
  assign led_out   = r_led;

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

`ifdef MEM_BUS_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mreq = 1'b0;
  logic        mwrite = 1'b0;
  logic [7:0]  address = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        mready;
  logic        merr;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [9:0]  sw_in = '0;
  logic [9:0]  led_out;

  always #5 clk = ~clk;

  mem_bus_responder dut (
    .clk      (clk),
    .reset    (reset),
    .mreq     (mreq),
    .mwrite   (mwrite),
    .address  (address),
    .wdata    (wdata),
    .rdata    (rdata),
    .mready   (mready),
    .merr     (merr),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .sw_in    (sw_in),
    .led_out  (led_out)
  );

  // RAM model: registered address from the DUT, combinational read
  logic [15:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
  end
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  int we_cnt = 0;
  int ack_cnt = 0;
  always @(posedge clk) begin
    if (ram_we) we_cnt++;
    if (mready) ack_cnt++;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic txn(input logic w, input logic [7:0] a, input logic [15:0] d,
                     output int lat, output logic [15:0] rd, output logic er);
    @(negedge clk);
    mreq = 1'b1; mwrite = w; address = a; wdata = d;
    @(posedge clk);
    #1 mreq = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (mready) begin
        rd = rdata;
        er = merr;
        break;
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [15:0] d;
    int          lat;
    logic [15:0] rd;
    logic [9:0]  led;
    logic        er;
    int          we;
  } vec_t;

  vec_t v[13];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    int lat, we0, ack0, cyc, got;
    logic [15:0] rd;
    logic er;
    logic [7:0]  b2b_addr [3];
    logic [15:0] b2b_exp  [3];

    v[0]  = '{1'b1, 8'h40, 16'h00A5, 2, 16'h0000, 10'h000, 1'b0, 1};
    v[1]  = '{1'b0, 8'h40, 16'h0000, 2, 16'h00A5, 10'h000, 1'b0, 0};
    v[2]  = '{1'b1, 8'hFE, 16'hFFFF, 1, 16'h00A5, 10'h3FF, 1'b0, 0};
    v[3]  = '{1'b0, 8'hFE, 16'h0000, 1, 16'h03FF, 10'h3FF, 1'b0, 0};
    v[4]  = '{1'b0, 8'hFF, 16'h0000, 1, 16'h0155, 10'h3FF, 1'b0, 0};
    v[5]  = '{1'b1, 8'hFF, 16'h1234, 1, 16'h0155, 10'h3FF, 1'b0, 0};
    v[6]  = '{1'b1, 8'h20, 16'h7777, 2, 16'h0155, 10'h3FF, PROT, PROT ? 0 : 1};
    v[7]  = '{1'b0, 8'h20, 16'h0000, 2, PROT ? 16'h1020 : 16'h7777, 10'h3FF, 1'b0, 0};
    v[8]  = '{1'b1, 8'h3F, 16'h5555, 2, PROT ? 16'h1020 : 16'h7777, 10'h3FF, PROT, PROT ? 0 : 1};
    v[9]  = '{1'b0, 8'h3F, 16'h0000, 2, PROT ? 16'h103F : 16'h5555, 10'h3FF, 1'b0, 0};
    v[10] = '{1'b1, 8'h80, 16'hBEEF, 2, PROT ? 16'h103F : 16'h5555, 10'h3FF, 1'b0, 1};
    v[11] = '{1'b0, 8'h80, 16'h0000, 2, 16'hBEEF, 10'h3FF, 1'b0, 0};
    v[12] = '{1'b0, 8'h41, 16'h0000, 2, 16'h1041, 10'h3FF, 1'b0, 0};

    // Power-on reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_mready", 32'(mready), 0);
    chk("rst_merr", 32'(merr), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_led", 32'(led_out), 0);
    reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of a RAM write's WAIT cycle drops the transaction
    we0 = we_cnt; ack0 = ack_cnt;
    @(negedge clk);
    mreq = 1'b1; mwrite = 1'b1; address = 8'h10; wdata = 16'hABCD;
    @(posedge clk);
    #1 mreq = 1'b0; reset = 1'b0;
    #1 chk("midwait_ram_we", 32'(ram_we), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("midwait_we_pulses", 32'(we_cnt - we0), 0);
    chk("midwait_acks", 32'(ack_cnt - ack0), 0);
    chk("midwait_led", 32'(led_out), 0);
    chk("midwait_mem10", 32'(mem[8'h10]), 32'h1010);
    chk("midwait_ram_addr", 32'(ram_addr), 0);
    // FSM back in IDLE: an I/O read is acknowledged one cycle after accept
    txn(1'b0, 8'hFE, 16'h0, lat, rd, er);
    chk("post_rst_io_lat", 32'(lat), 1);
    chk("post_rst_io_rdata", 32'(rd), 0);

    sw_in = 10'h155;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      we0 = we_cnt; ack0 = ack_cnt;
      txn(v[i].w, v[i].a, v[i].d, lat, rd, er);
      @(negedge clk);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(v[i].rd));
      chk($sformatf("v%0d_merr", i), 32'(er), 32'(v[i].er));
      chk($sformatf("v%0d_led", i), 32'(led_out), 32'(v[i].led));
      chk($sformatf("v%0d_we_pulses", i), 32'(we_cnt - we0), 32'(v[i].we));
      chk($sformatf("v%0d_acks", i), 32'(ack_cnt - ack0), 1);
    end
    chk("mem40", 32'(mem[8'h40]), 32'h00A5);
    chk("memFF_untouched", 32'(mem[8'hFF]), 32'h10FF);

    // mreq held high across three back-to-back reads
    b2b_addr[0] = 8'h41; b2b_addr[1] = 8'h42; b2b_addr[2] = 8'hFE;
    b2b_exp[0] = 16'h1041; b2b_exp[1] = 16'h1042; b2b_exp[2] = 16'h03FF;
    ack0 = ack_cnt;
    @(negedge clk);
    mreq = 1'b1; mwrite = 1'b0; address = b2b_addr[0];
    got = 0; cyc = 0;
    while (got < 3 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (mready) begin
        chk($sformatf("b2b%0d_rdata", got), 32'(rdata), 32'(b2b_exp[got]));
        got++;
        if (got < 3) address = b2b_addr[got];
        else mreq = 1'b0;
      end
    end
    mreq = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_responses", 32'(got), 3);
    chk("b2b_cycles", 32'(cyc), 7);
    chk("b2b_acks", 32'(ack_cnt - ack0), 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
